// File: rtl/image_pkg.sv
// Shared constants and FSM state type for the image RAM streamer.
package image_pkg;

  localparam int unsigned IMG_ROWS  = 49;
  localparam int unsigned IMG_WIDTH = 64;
  localparam int unsigned ADDR_W    = 7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLoad,
    StShift,
    StDone
  } stream_state_e;

endpackage

// File: rtl/image_ram_streamer_if.sv
// RAM read port and serial pixel stream shared by the streamer and its environment.
interface image_ram_streamer_if #(
  parameter int unsigned IMG_WIDTH = image_pkg::IMG_WIDTH,
  parameter int unsigned ADDR_W    = image_pkg::ADDR_W
);

  logic [ADDR_W-1:0]    ramaddress;
  logic                 read_request;
  logic [IMG_WIDTH-1:0] ramdata;
  logic                 pix_data;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 row_last;
  logic                 frame_last;

  modport master (
    output ramaddress, read_request, pix_data, pix_valid, row_last, frame_last,
    input  ramdata, pix_ready
  );

  modport slave (
    input  ramaddress, read_request, pix_data, pix_valid, row_last, frame_last,
    output ramdata, pix_ready
  );

endinterface

// File: rtl/row_serializer.sv
// Serialises one captured RAM word LSB first; STREAM_ROW_PARITY_EN appends an
// even-parity beat to each row and moves row_last onto it.
module row_serializer #(
  parameter int unsigned IMG_WIDTH = image_pkg::IMG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 accept,
  input  logic [IMG_WIDTH-1:0] ramdata,
  output logic                 pix_data,
  output logic                 row_last
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH) + 1;

`ifdef STREAM_ROW_PARITY_EN
  localparam int unsigned LastCol = IMG_WIDTH;
`else
  localparam int unsigned LastCol = IMG_WIDTH - 1;
`endif

  localparam logic [ColW-1:0] LastColV = ColW'(LastCol);

  logic [IMG_WIDTH-1:0] shift_q;
  logic [ColW-1:0]      col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      col_q   <= '0;
    end else if (load) begin
      shift_q <= ramdata;
      col_q   <= '0;
    end else if (accept) begin
      shift_q <= shift_q >> 1;
      col_q   <= col_q + ColW'(1);
    end
  end

  assign row_last = (col_q == LastColV);

`ifdef STREAM_ROW_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^ramdata;
    end
  end

  assign pix_data = row_last ? parity_q : shift_q[0];
`else
  assign pix_data = shift_q[0];
`endif

endmodule

// File: rtl/image_ram_streamer.sv
// Streams a frame of IMG_ROWS RAM words as a 1-bit pixel stream, one row read
// per row. Optional parity beat per row via STREAM_ROW_PARITY_EN (see row_serializer).
module image_ram_streamer #(
  parameter int unsigned IMG_ROWS  = image_pkg::IMG_ROWS,
  parameter int unsigned IMG_WIDTH = image_pkg::IMG_WIDTH,
  parameter int unsigned ADDR_W    = image_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  image_ram_streamer_if.master        bus
);

  import image_pkg::*;

  stream_state_e     state_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] ramaddress_q;
  logic              read_request_q;
  logic              pix_valid_q;
  logic              busy_q;
  logic              done_q;

  logic ser_data;
  logic ser_row_last;
  logic accept;
  logic last_row;

  assign accept   = pix_valid_q & bus.pix_ready;
  assign last_row = (row_q == ADDR_W'(IMG_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      row_q          <= '0;
      ramaddress_q   <= '0;
      read_request_q <= 1'b0;
      pix_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      read_request_q <= 1'b0;
      done_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StReq;
            row_q          <= '0;
            ramaddress_q   <= '0;
            read_request_q <= 1'b1;
            busy_q         <= 1'b1;
          end
        end
        StReq: state_q <= StLoad;
        StLoad: begin
          state_q     <= StShift;
          pix_valid_q <= 1'b1;
        end
        StShift: begin
          if (accept && ser_row_last) begin
            pix_valid_q <= 1'b0;
            if (last_row) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // Address goes out with the strobe, so it follows the new row.
              state_q        <= StReq;
              row_q          <= row_q + ADDR_W'(1);
              ramaddress_q   <= row_q + ADDR_W'(1);
              read_request_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  row_serializer #(
    .IMG_WIDTH (IMG_WIDTH)
  ) u_row_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == StLoad),
    .accept   (accept),
    .ramdata  (bus.ramdata),
    .pix_data (ser_data),
    .row_last (ser_row_last)
  );

  assign bus.ramaddress   = ramaddress_q;
  assign bus.read_request = read_request_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_data     = pix_valid_q & ser_data;
  assign bus.row_last     = pix_valid_q & ser_row_last;
  assign bus.frame_last   = pix_valid_q & ser_row_last & last_row;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_image_ram_streamer.sv
// Scoreboard bench for image_ram_streamer: RAM model, expected beat/address queues,
// latency, stall, ignored-start and mid-frame reset scenarios.
module tb_image_ram_streamer;

  import image_pkg::*;

`ifdef STREAM_ROW_PARITY_EN
  localparam int BPR = IMG_WIDTH + 1;
`else
  localparam int BPR = IMG_WIDTH;
`endif
  localparam int TOTAL  = IMG_ROWS * BPR;
  localparam int BUDGET = 20000;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  image_ram_streamer_if bus_if ();

  image_ram_streamer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  logic [IMG_WIDTH-1:0] mem [IMG_ROWS];
  logic [2:0]           sb_q[$];
  logic [ADDR_W-1:0]    addr_q[$];
  int checks = 0;
  int errors = 0;
  int beats_acc = 0;
  int done_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus_if.read_request === 1'b1) bus_if.ramdata <= mem[int'(bus_if.ramaddress)];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.pix_valid === 1'b1) begin
      check("sb_underflow", 64'(sb_q.size() == 0), 64'd0);
      if (sb_q.size() != 0) begin
        check("beat", {bus_if.pix_data, bus_if.row_last, bus_if.frame_last}, sb_q[0]);
        if (bus_if.pix_ready === 1'b1) begin
          void'(sb_q.pop_front());
          beats_acc++;
        end
      end
    end
    if (bus_if.read_request === 1'b1) begin
      check("addr_underflow", 64'(addr_q.size() == 0), 64'd0);
      if (addr_q.size() != 0) check("ramaddress", bus_if.ramaddress, addr_q.pop_front());
    end
    if (done === 1'b1) done_count++;
  end

  task automatic push_frame();
    logic [IMG_WIDTH-1:0] w;
    logic d, rl, fl;
    for (int r = 0; r < IMG_ROWS; r++) begin
      addr_q.push_back(ADDR_W'(r));
      w = mem[r];
      for (int c = 0; c < BPR; c++) begin
        d  = (c < IMG_WIDTH) ? w[c] : ^w;
        rl = (c == BPR - 1);
        fl = rl && (r == IMG_ROWS - 1);
        sb_q.push_back({d, rl, fl});
      end
    end
    beats_acc = 0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ramaddress"}, bus_if.ramaddress, 64'd0);
    check({pfx, "_read_request"}, bus_if.read_request, 64'd0);
    check({pfx, "_pix_data"}, bus_if.pix_data, 64'd0);
    check({pfx, "_pix_valid"}, bus_if.pix_valid, 64'd0);
    check({pfx, "_row_last"}, bus_if.row_last, 64'd0);
    check({pfx, "_frame_last"}, bus_if.frame_last, 64'd0);
    check({pfx, "_busy"}, busy, 64'd0);
    check({pfx, "_done"}, done, 64'd0);
  endtask

  task automatic run_frame(input bit toggle, input bit restart);
    int base_done;
    int cyc;
    bit pulsed;
    base_done = done_count;
    cyc = 0;
    pulsed = 1'b0;
    push_frame();
    @(posedge clk);
    #1 start = 1'b1;
    bus_if.pix_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("lat_read_request", bus_if.read_request, 64'd1);
    check("lat_addr0", bus_if.ramaddress, 64'd0);
    check("lat_busy", busy, 64'd1);
    check("lat_no_valid_req", bus_if.pix_valid, 64'd0);
    @(negedge clk);
    check("lat_load", {bus_if.read_request, bus_if.pix_valid}, 64'd0);
    @(negedge clk);
    check("lat_first_valid", bus_if.pix_valid, 64'd1);
    while (done_count == base_done && cyc < BUDGET) begin
      @(posedge clk);
      #1 cyc++;
      if (toggle) bus_if.pix_ready = ~bus_if.pix_ready;
      start = 1'b0;
      if (restart && !pulsed && beats_acc == 10 * BPR + 3) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    bus_if.pix_ready = 1'b1;
    check("frame_timeout", 64'(cyc >= BUDGET), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_pulses", 64'(done_count - base_done), 64'd1);
    check("busy_after", busy, 64'd0);
    check("beats_total", 64'(beats_acc), 64'(TOTAL));
    check("sb_left", 64'(sb_q.size()), 64'd0);
    check("addr_left", 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    int base_done;
    rst = 1'b1;
    start = 1'b0;
    bus_if.pix_ready = 1'b0;
    for (int r = 0; r < IMG_ROWS; r++) mem[r] = {$urandom(), $urandom()};
    mem[0] = 64'h0000_0000_0000_0001;
    mem[1] = 64'h0000_0000_0000_0007;
    mem[IMG_ROWS-1] = 64'h8000_0000_0000_0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst_init");
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);

    // Abandon a frame at row 20, column 5.
    push_frame();
    base_done = done_count;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (beats_acc < 20 * BPR + 5 && cyc < BUDGET) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("abort_reach_timeout", 64'(cyc >= BUDGET), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid");
    sb_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", 64'(done_count - base_done), 64'd0);
    check("abort_idle_busy", busy, 64'd0);

    run_frame(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_ram_streamer.md
IMAGE_RAM_STREAMER -- requirements
Module: image_ram_streamer

Interface
REQ-001 Parameter IMG_ROWS, default 49, number of image rows held in result RAM.
REQ-002 Parameter IMG_WIDTH, default 64, pixels (bits) per row and RAM word width.
REQ-003 Parameter ADDR_W, default 7, RAM address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to stream one full frame; sampled only in IDLE.
REQ-007 ramaddress  output  ADDR_W  RAM row address being read.
REQ-008 read_request  output  1  RAM read strobe, one cycle per row.
REQ-009 ramdata  input  IMG_WIDTH  RAM read data, valid the cycle after read_request.
REQ-010 pix_data  output  1  current pixel bit.
REQ-011 pix_valid  output  1  pix_data valid.
REQ-012 pix_ready  input  1  downstream accepts the beat when pix_valid & pix_ready.
REQ-013 row_last  output  1  marks the final beat of a row.
REQ-014 frame_last  output  1  marks the final beat of the frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the frame's final beat is accepted.

Function
REQ-017 FSM states: IDLE, REQ, LOAD, SHIFT, DONE.
REQ-018 IDLE->REQ on start=1, row counter cleared to 0.
REQ-019 REQ: read_request=1, ramaddress=row counter; next state LOAD unconditionally.
REQ-020 LOAD: ramdata captured into the row shift register, column counter cleared; next state SHIFT.
REQ-021 SHIFT: pix_valid=1, pix_data=shift register bit 0 (pixel 0 first).
REQ-022 On accepted beat: shift right one bit, column counter +1.
REQ-023 pix_ready=0 in SHIFT: pix_data, row_last, frame_last and counters held stable.
REQ-024 row_last=1 on column IMG_WIDTH-1; frame_last=1 additionally when row = IMG_ROWS-1.
REQ-025 Accepted row_last beat with row < IMG_ROWS-1: row counter +1, next state REQ.
REQ-026 Accepted frame_last beat: next state DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-027 Latency: start at edge N -> read_request during cycle N+1 -> first pix_valid during cycle N+3.
REQ-028 Inter-row gap: exactly two cycles (REQ, LOAD) with pix_valid=0.
REQ-029 start while busy is ignored; no queued frame.
REQ-030 Counters never wrap within a frame; row counter width ADDR_W, column counter clog2(IMG_WIDTH)+1 bits.
REQ-031 read_request=0 and pix_valid=0 in IDLE, LOAD, DONE.

Reset
REQ-032 rst has priority over all other inputs, including mid-row/mid-frame.
REQ-033 After rst: state IDLE; ramaddress=0, read_request=0, pix_data=0, pix_valid=0, row_last=0, frame_last=0, busy=0, done=0; counters and shift register cleared.
REQ-034 An interrupted frame is abandoned; done is not pulsed.

Configuration
REQ-035 Macro STREAM_ROW_PARITY_EN defined: each row emits IMG_WIDTH+1 beats; extra final beat carries even parity (XOR) of the captured row word; row_last/frame_last move to that beat.
REQ-036 Macro undefined: exactly IMG_WIDTH beats per row, no parity logic present.

Structure
REQ-037 Shared package image_pkg: IMG_ROWS, IMG_WIDTH, ADDR_W constants and streamer state enum typedef.
REQ-038 Sub-module row_serializer: load, shift-on-accept register, column counter, row_last generation, parity beat under STREAM_ROW_PARITY_EN.

Verification
REQ-039 Reset then start pulse, pix_ready=1 constant -> 3136 beats, read_request at addresses 0..48 in order, one done pulse, first pix_valid 3 cycles after start edge.
REQ-040 Row 0 = 64'h0000_0000_0000_0001 -> beat 0 pix_data=1, beats 1..63 pix_data=0, row_last on beat 63.
REQ-041 pix_ready toggled 1/0 every cycle -> identical beat sequence to REQ-039, outputs stable on stalled cycles, frame_last only on beat 3135.
REQ-042 start asserted again during row 10 -> ignored; frame completes unchanged, single done.
REQ-043 rst asserted at row 20 column 5 -> next cycle all outputs at reset values, busy=0, no done; fresh start streams from address 0.
REQ-044 STREAM_ROW_PARITY_EN defined, row = 64'h0000_0000_0000_0007 -> 65 beats, beat 64 pix_data=1 with row_last; frame total 3185 beats.
